alarm_arm_sequencer: RTL and testbench

Arming/alarm sequencer for the three-zone alarm system: turns debounced arm and panic keys plus raw zone sensors into a sequenced state. The sequence covers exit delay, armed, entry delay, timed siren, silenced and panic. It sits between the key debouncers and the LED/siren output drivers, and runs on the fast clock with a 50 ms tick enable.

---
 rtl/alarm_arm_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_arm_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_arm_sequencer.sv
// Arming/alarm sequencer: exit delay, armed, entry delay, timed siren, silenced and panic.
// Optional delay chime is built only when ALARM_SEQ_CHIME_EN is defined.
module alarm_arm_sequencer #(
    parameter int unsigned EXIT_TICKS  = 100,
    parameter int unsigned ENTRY_TICKS = 60,
    parameter int unsigned SIREN_TICKS = 1200,
    parameter int unsigned CNT_W       = 12
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             tick,
    input  logic             arm_key,
    input  logic             panic_key,
    input  logic [2:0]       zone_in,
    input  logic [2:0]       instant_mask,
    output logic [2:0]       state,
    output logic             siren_en,
    output logic             strobe_en,
    output logic             armed_led,
    output logic             disarmed_led,
    output logic [2:0]       zone_latched,
    output logic             arm_fault,
    output logic [CNT_W-1:0] remaining,
    output logic             chime
);

    typedef enum logic [2:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StAlarm      = 3'd4,
        StSilenced   = 3'd5,
        StPanic      = 3'd6,
        StInvalid    = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_TICKS);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       zl_q, zl_d;
    logic             arm_prev_q, panic_prev_q;
    logic             fault_q, fault_d;
    logic             siren_q, strobe_q, armed_led_q, disarmed_led_q;

    logic arm_rise, panic_rise, expire, instant_hit;

    assign arm_rise    = arm_key & ~arm_prev_q;
    assign panic_rise  = panic_key & ~panic_prev_q;
    assign expire      = tick && (rem_q == CntOne);
    assign instant_hit = |(zone_in & instant_mask);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        zl_d    = zl_q;
        fault_d = 1'b0;
        if (panic_rise) begin
            state_d = StPanic;
            rem_d   = '0;
        end else if (arm_rise) begin
            if (state_q == StDisarmed) begin
                if (zone_in == 3'b000) begin
                    state_d = StExitDelay;
                    rem_d   = ExitLoad;
                    zl_d    = 3'b000;
                end else begin
                    fault_d = 1'b1;
                end
            end else begin
                // Disarm from any other state keeps the alarm history in zl.
                state_d = StDisarmed;
                rem_d   = '0;
            end
        end else begin
            unique case (state_q)
                StDisarmed: rem_d = '0;
                StExitDelay: begin
                    if (expire) begin
                        state_d = StArmed;
                        rem_d   = '0;
                    end else if (tick && rem_q != '0) begin
                        rem_d = rem_q - CntOne;
                    end
                end
                StArmed: begin
                    if (instant_hit) begin
                        state_d = StAlarm;
                        rem_d   = SirenLoad;
                        zl_d    = zl_q | zone_in;
                    end else if (zone_in != 3'b000) begin
                        state_d = StEntryDelay;
                        rem_d   = EntryLoad;
                        zl_d    = zl_q | zone_in;
                    end
                end
                StEntryDelay: begin
                    if (instant_hit || expire) begin
                        state_d = StAlarm;
                        rem_d   = SirenLoad;
                        zl_d    = zl_q | zone_in;
                    end else if (tick && rem_q != '0) begin
                        rem_d = rem_q - CntOne;
                    end
                end
                StAlarm: begin
                    zl_d = zl_q | zone_in;
                    if (expire) begin
                        state_d = StSilenced;
                        rem_d   = '0;
                    end else if (tick && rem_q != '0) begin
                        rem_d = rem_q - CntOne;
                    end
                end
                StSilenced: begin
                    // Only a zone not already part of this alarm re-arms the siren.
                    if (|(zone_in & ~zl_q)) begin
                        state_d = StAlarm;
                        rem_d   = SirenLoad;
                        zl_d    = zl_q | zone_in;
                    end
                end
                StPanic: rem_d = '0;
                default: begin
                    state_d = StDisarmed;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q        <= StDisarmed;
            rem_q          <= '0;
            zl_q           <= 3'b000;
            arm_prev_q     <= 1'b1;
            panic_prev_q   <= 1'b1;
            fault_q        <= 1'b0;
            siren_q        <= 1'b0;
            strobe_q       <= 1'b0;
            armed_led_q    <= 1'b0;
            disarmed_led_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            zl_q           <= zl_d;
            arm_prev_q     <= arm_key;
            panic_prev_q   <= panic_key;
            fault_q        <= fault_d;
            siren_q        <= (state_d == StAlarm) || (state_d == StPanic);
            strobe_q       <= (state_d == StAlarm) || (state_d == StSilenced) ||
                              (state_d == StPanic);
            armed_led_q    <= (state_d == StArmed) || (state_d == StEntryDelay) ||
                              (state_d == StAlarm) || (state_d == StSilenced) ||
                              (state_d == StPanic);
            disarmed_led_q <= (state_d == StDisarmed) || (state_d == StExitDelay);
        end
    end

`ifdef ALARM_SEQ_CHIME_EN
    logic chime_q, chime_d;
    logic in_delay_q, in_delay_d;

    assign in_delay_q = (state_q == StExitDelay) || (state_q == StEntryDelay);
    assign in_delay_d = (state_d == StExitDelay) || (state_d == StEntryDelay);

    always_comb begin
        chime_d = 1'b0;
        if (in_delay_d) begin
            chime_d = (in_delay_q && tick) ? ~chime_q : chime_q;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= chime_d;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign state        = state_q;
    assign remaining    = rem_q;
    assign zone_latched = zl_q;
    assign arm_fault    = fault_q;
    assign siren_en     = siren_q;
    assign strobe_en    = strobe_q;
    assign armed_led    = armed_led_q;
    assign disarmed_led = disarmed_led_q;

endmodule

// File: tb/tb_alarm_arm_sequencer.sv
// Scoreboard bench for alarm_arm_sequencer: directed vectors, expectations queued and checked
// by an independent monitor on the falling edge.
module tb_alarm_arm_sequencer;

    localparam int unsigned CW = 4;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          tick, arm_key, panic_key;
    logic [2:0]    zone_in, instant_mask;
    logic [2:0]    state;
    logic          siren_en, strobe_en, armed_led, disarmed_led, arm_fault, chime;
    logic [2:0]    zone_latched;
    logic [CW-1:0] remaining;

    alarm_arm_sequencer #(
        .EXIT_TICKS (3),
        .ENTRY_TICKS(2),
        .SIREN_TICKS(2),
        .CNT_W      (CW)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .tick        (tick),
        .arm_key     (arm_key),
        .panic_key   (panic_key),
        .zone_in     (zone_in),
        .instant_mask(instant_mask),
        .state       (state),
        .siren_en    (siren_en),
        .strobe_en   (strobe_en),
        .armed_led   (armed_led),
        .disarmed_led(disarmed_led),
        .zone_latched(zone_latched),
        .arm_fault   (arm_fault),
        .remaining   (remaining),
        .chime       (chime)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [2:0]    st;
        logic          sir;
        logic          stb;
        logic          al;
        logic          dl;
        logic [2:0]    zl;
        logic          flt;
        logic [CW-1:0] rem;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic drive(input logic tk, input logic ak, input logic pk,
                         input logic [2:0] zn, input logic [2:0] mk);
        tick         = tk;
        arm_key      = ak;
        panic_key    = pk;
        zone_in      = zn;
        instant_mask = mk;
        @(posedge iCLK);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [2:0] st, input logic sir,
                              input logic stb, input logic al, input logic dl,
                              input logic [2:0] zl, input logic flt, input logic [CW-1:0] rem);
        exp_t e;
        e.st  = st;
        e.sir = sir;
        e.stb = stb;
        e.al  = al;
        e.dl  = dl;
        e.zl  = zl;
        e.flt = flt;
        e.rem = rem;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Press arm from DISARMED with zones closed and let the 3-tick exit delay run out.
    task automatic arm_to_armed();
        drive(0, 1, 0, 3'b000, 3'b000);
        drive(0, 0, 0, 3'b000, 3'b000);
        repeat (3) drive(1, 0, 0, 3'b000, 3'b000);
    endtask

    always @(negedge iCLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e, a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.st  = state;
            a.sir = siren_en;
            a.stb = strobe_en;
            a.al  = armed_led;
            a.dl  = disarmed_led;
            a.zl  = zone_latched;
            a.flt = arm_fault;
            a.rem = remaining;
            n_checks++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%0d sir=%b stb=%b al=%b dl=%b zl=%b flt=%b rem=%0d, want st=%0d sir=%b stb=%b al=%b dl=%b zl=%b flt=%b rem=%0d",
                         nm, a.st, a.sir, a.stb, a.al, a.dl, a.zl, a.flt, a.rem,
                         e.st, e.sir, e.stb, e.al, e.dl, e.zl, e.flt, e.rem);
            end
        end
    end

    initial begin
        iRST = 1'b1;
        drive(0, 1, 0, 3'b000, 3'b000);
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("reset", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        iRST = 1'b0;
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("held_arm_no_rise", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);

        drive(0, 1, 0, 3'b010, 3'b000);
        expect_out("arm_refused", 0, 0, 0, 0, 1, 3'b000, 1, 0);
        drive(0, 1, 0, 3'b010, 3'b000);
        expect_out("fault_one_cycle", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);

        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("exit_enter", 1, 0, 0, 0, 1, 3'b000, 0, 3);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("exit_tick1", 1, 0, 0, 0, 1, 3'b000, 0, 2);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("exit_tick2", 1, 0, 0, 0, 1, 3'b000, 0, 1);
        drive(0, 0, 0, 3'b001, 3'b000);
        expect_out("exit_zone_ignored", 1, 0, 0, 0, 1, 3'b000, 0, 1);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("armed", 2, 0, 0, 1, 0, 3'b000, 0, 0);

        drive(0, 0, 0, 3'b001, 3'b000);
        expect_out("entry_enter", 3, 0, 0, 1, 0, 3'b001, 0, 2);
        drive(1, 0, 0, 3'b001, 3'b000);
        expect_out("entry_tick1", 3, 0, 0, 1, 0, 3'b001, 0, 1);
        drive(1, 0, 0, 3'b001, 3'b000);
        expect_out("entry_to_alarm", 4, 1, 1, 1, 0, 3'b001, 0, 2);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("alarm_tick1", 4, 1, 1, 1, 0, 3'b001, 0, 1);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("silenced", 5, 0, 1, 1, 0, 3'b001, 0, 0);
        drive(0, 0, 0, 3'b001, 3'b000);
        expect_out("silenced_known_zone", 5, 0, 1, 1, 0, 3'b001, 0, 0);
        drive(0, 0, 0, 3'b100, 3'b000);
        expect_out("retrigger", 4, 1, 1, 1, 0, 3'b101, 0, 2);
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("alarm_disarm_holds_zl", 0, 0, 0, 0, 1, 3'b101, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);

        arm_to_armed();
        expect_out("rearmed_zl_cleared", 2, 0, 0, 1, 0, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b010, 3'b010);
        expect_out("instant_alarm", 4, 1, 1, 1, 0, 3'b010, 0, 2);
        drive(0, 1, 0, 3'b000, 3'b010);
        expect_out("instant_disarm", 0, 0, 0, 0, 1, 3'b010, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);

        arm_to_armed();
        drive(0, 1, 1, 3'b000, 3'b000);
        expect_out("panic_beats_arm", 6, 1, 1, 1, 0, 3'b000, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000);
        expect_out("panic_no_timeout", 6, 1, 1, 1, 0, 3'b000, 0, 0);
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("panic_disarm", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);

        arm_to_armed();
        drive(0, 0, 0, 3'b001, 3'b000);
        expect_out("entry2", 3, 0, 0, 1, 0, 3'b001, 0, 2);
        drive(0, 0, 0, 3'b011, 3'b010);
        expect_out("entry_instant", 4, 1, 1, 1, 0, 3'b011, 0, 2);
        drive(0, 1, 0, 3'b000, 3'b000);
        drive(0, 0, 0, 3'b000, 3'b000);

        arm_to_armed();
        drive(0, 0, 0, 3'b001, 3'b000);
        expect_out("entry3", 3, 0, 0, 1, 0, 3'b001, 0, 2);
        iRST = 1'b1;
        drive(1, 1, 0, 3'b001, 3'b000);
        expect_out("reset_mid_entry", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        iRST = 1'b0;
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("arm_held_over_reset", 0, 0, 0, 0, 1, 3'b000, 0, 0);
        drive(0, 0, 0, 3'b000, 3'b000);
        drive(0, 1, 0, 3'b000, 3'b000);
        expect_out("arm_after_reset", 1, 0, 0, 0, 1, 3'b000, 0, 3);
        drive(0, 0, 0, 3'b000, 3'b000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge iCLK);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
